// File: rtl/wb_stage_pkg.sv
// Shared types and constants for the writeback stage: load-type encoding,
// load-queue entry layout and default sizes.
package wb_stage_pkg;
  localparam int XLEN           = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int LQ_DEPTH       = 2;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } ld_funct3_e;

  typedef struct packed {
    logic                      live;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [XLEN-1:0]           data;
  } wb_entry_t;
endpackage

// File: rtl/wb_stage_if.sv
// Bus bundle for wb_stage: ALU result path, load return handshake,
// register-file write port, hazard mask and performance counters.
interface wb_stage_if;
  import wb_stage_pkg::*;

  logic                         alu_valid;
  logic [REG_ADDR_WIDTH-1:0]    alu_rd;
  logic [XLEN-1:0]              alu_data;
  logic                         ld_valid;
  logic                         ld_ready;
  logic [REG_ADDR_WIDTH-1:0]    ld_rd;
  logic [2:0]                   ld_funct3;
  logic [1:0]                   ld_addr_lo;
  logic [XLEN-1:0]              ld_rdata;
  logic                         rf_web;
  logic [REG_ADDR_WIDTH-1:0]    rf_addr;
  logic [XLEN-1:0]              rf_data;
  logic [2**REG_ADDR_WIDTH-1:0] pend_mask;
  logic [31:0]                  perf_wr_cnt;
  logic [31:0]                  perf_kill_cnt;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output ld_valid, ld_rd, ld_funct3, ld_addr_lo, ld_rdata,
    input  ld_ready, rf_web, rf_addr, rf_data, pend_mask,
    input  perf_wr_cnt, perf_kill_cnt
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  ld_valid, ld_rd, ld_funct3, ld_addr_lo, ld_rdata,
    output ld_ready, rf_web, rf_addr, rf_data, pend_mask,
    output perf_wr_cnt, perf_kill_cnt
  );
endinterface

// File: rtl/wb_stage_load_align.sv
// Combinational load data alignment: selects byte/half/word from the raw
// memory word by funct3 and address offset, then sign- or zero-extends.
module load_align
  import wb_stage_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] aligned
);

  function automatic logic [XLEN-1:0] ext8(input logic [7:0] b, input logic sgn);
    return {{(XLEN-8){sgn & b[7]}}, b};
  endfunction

  function automatic logic [XLEN-1:0] ext16(input logic [15:0] h, input logic sgn);
    return {{(XLEN-16){sgn & h[15]}}, h};
  endfunction

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte  = rdata[{addr_lo, 3'b000} +: 8];
    w_half  = rdata[{addr_lo[1], 4'b0000} +: 16];
    aligned = rdata;
    case (funct3)
      LB:      aligned = ext8(w_byte, 1'b1);
      LBU:     aligned = ext8(w_byte, 1'b0);
      LH:      aligned = ext16(w_half, 1'b1);
      LHU:     aligned = ext16(w_half, 1'b0);
      default: aligned = rdata;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: ALU results win the register-file port; load returns wait
// in a small FIFO and are killed by younger ALU writes. Optional WB_PERF_CNT_EN.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int LQ_DEPTH = wb_stage_pkg::LQ_DEPTH
) (
  input logic        clk,
  input logic        rst,
  wb_stage_if.slave  bus
);

  localparam int PTR_W = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
  localparam int CNT_W = $clog2(LQ_DEPTH + 1);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(LQ_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  wb_entry_t                    r_lq [LQ_DEPTH];
  logic [PTR_W-1:0]             r_rptr;
  logic [PTR_W-1:0]             r_wptr;
  logic [CNT_W-1:0]             r_count;
  logic                         r_rf_web;
  logic [REG_ADDR_WIDTH-1:0]    r_rf_addr;
  logic [XLEN-1:0]              r_rf_data;

  logic                         w_alu_wr;
  logic                         w_enq;
  logic                         w_enq_kill;
  logic                         w_deq;
  logic [XLEN-1:0]              w_aligned;
  wb_entry_t                    w_head;
  logic [2**REG_ADDR_WIDTH-1:0] w_pend;

  load_align u_align (
    .funct3  (bus.ld_funct3),
    .addr_lo (bus.ld_addr_lo),
    .rdata   (bus.ld_rdata),
    .aligned (w_aligned)
  );

  assign bus.ld_ready = rst && (r_count < CNT_W'(LQ_DEPTH));
  assign w_alu_wr     = bus.alu_valid && (bus.alu_rd != '0);
  // x0 loads complete the handshake but never occupy a slot
  assign w_enq        = bus.ld_valid && bus.ld_ready && (bus.ld_rd != '0);
  assign w_enq_kill   = w_alu_wr && (bus.ld_rd == bus.alu_rd);
  assign w_deq        = !w_alu_wr && (r_count != '0);
  assign w_head       = r_lq[r_rptr];

  // Free slots always have live=0, so the mask only sees occupied entries
  always_comb begin
    w_pend = '0;
    for (int i = 0; i < LQ_DEPTH; i++)
      if (r_lq[i].live) w_pend[r_lq[i].rd] = 1'b1;
  end
  assign bus.pend_mask = w_pend;

  // Queue: kill, dequeue and enqueue; enqueue last so its live bit wins
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < LQ_DEPTH; i++) r_lq[i].live <= 1'b0;
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else begin
      for (int i = 0; i < LQ_DEPTH; i++)
        if (w_alu_wr && (r_lq[i].rd == bus.alu_rd)) r_lq[i].live <= 1'b0;
      if (w_deq) begin
        r_lq[r_rptr].live <= 1'b0;
        r_rptr            <= ptr_inc(r_rptr);
      end
      if (w_enq) begin
        r_lq[r_wptr] <= '{live: !w_enq_kill, rd: bus.ld_rd, data: w_aligned};
        r_wptr       <= ptr_inc(r_wptr);
      end
      r_count <= r_count + CNT_W'(w_enq) - CNT_W'(w_deq);
    end
  end

  // Output register stage
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rf_web  <= 1'b0;
      r_rf_addr <= '0;
      r_rf_data <= '0;
    end else if (w_alu_wr) begin
      r_rf_web  <= 1'b1;
      r_rf_addr <= bus.alu_rd;
      r_rf_data <= bus.alu_data;
    end else if (w_deq && w_head.live) begin
      r_rf_web  <= 1'b1;
      r_rf_addr <= w_head.rd;
      r_rf_data <= w_head.data;
    end else begin
      r_rf_web  <= 1'b0;
    end
  end

  assign bus.rf_web  = r_rf_web;
  assign bus.rf_addr = r_rf_addr;
  assign bus.rf_data = r_rf_data;

`ifdef WB_PERF_CNT_EN
  logic [31:0] r_wr_cnt;
  logic [31:0] r_kill_cnt;
  logic [31:0] w_kill_n;

  always_comb begin
    w_kill_n = 32'(w_enq && w_enq_kill);
    for (int i = 0; i < LQ_DEPTH; i++)
      w_kill_n = w_kill_n + 32'(w_alu_wr && r_lq[i].live && (r_lq[i].rd == bus.alu_rd));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_cnt   <= '0;
      r_kill_cnt <= '0;
    end else begin
      r_wr_cnt   <= r_wr_cnt + 32'(r_rf_web);
      r_kill_cnt <= r_kill_cnt + w_kill_n;
    end
  end

  assign bus.perf_wr_cnt   = r_wr_cnt;
  assign bus.perf_kill_cnt = r_kill_cnt;
`else
  assign bus.perf_wr_cnt   = '0;
  assign bus.perf_kill_cnt = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: reset, ALU writes, load extension, priority,
// backpressure, kill, x0 handling and mid-operation reset.
module tb_wb_stage;
  import wb_stage_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  wb_stage_if bus ();

  wb_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef WB_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.alu_valid  = 1'b0;
    bus.alu_rd     = '0;
    bus.alu_data   = '0;
    bus.ld_valid   = 1'b0;
    bus.ld_rd      = '0;
    bus.ld_funct3  = '0;
    bus.ld_addr_lo = '0;
    bus.ld_rdata   = '0;
  endtask

  task automatic set_ld(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lo,
                        input logic [31:0] rdata);
    bus.ld_valid   = 1'b1;
    bus.ld_rd      = rd;
    bus.ld_funct3  = f3;
    bus.ld_addr_lo = lo;
    bus.ld_rdata   = rdata;
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [1:0] lo,
                         input logic [31:0] exp);
    set_ld(5'd7, f3, lo, 32'h80FF_7F01);
    chk({tag, "_ready"}, bus.ld_ready, 1);
    step();
    bus.ld_valid = 1'b0;
    chk({tag, "_web_n1"}, bus.rf_web, 0);
    chk({tag, "_pend"}, bus.pend_mask[7], 1);
    step();
    chk({tag, "_web_n2"}, bus.rf_web, 1);
    chk({tag, "_addr"}, bus.rf_addr, 7);
    chk({tag, "_data"}, bus.rf_data, exp);
    chk({tag, "_pend_clr"}, bus.pend_mask, 0);
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [1:0]  lo;
    logic [31:0] exp;
  } ld_vec_t;

  ld_vec_t ld_vecs [6] = '{
    '{3'b000, 2'd3, 32'hFFFF_FF80},
    '{3'b100, 2'd3, 32'h0000_0080},
    '{3'b001, 2'd2, 32'hFFFF_80FF},
    '{3'b000, 2'd0, 32'h0000_0001},
    '{3'b101, 2'd0, 32'h0000_7F01},
    '{3'b010, 2'd1, 32'h80FF_7F01}
  };

  initial begin
    idle_inputs();
    rst = 1'b0;
    repeat (3) step();
    chk("rst_web", bus.rf_web, 0);
    chk("rst_addr", bus.rf_addr, 0);
    chk("rst_data", bus.rf_data, 0);
    chk("rst_ready", bus.ld_ready, 0);
    chk("rst_pend", bus.pend_mask, 0);
    chk("rst_wrcnt", bus.perf_wr_cnt, 0);
    chk("rst_killcnt", bus.perf_kill_cnt, 0);
    rst = 1'b1;
    #1;
    chk("rel_ready", bus.ld_ready, 1);

    // single ALU write
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd5;
    bus.alu_data  = 32'h0000_1234;
    step();
    bus.alu_valid = 1'b0;
    chk("alu_web", bus.rf_web, 1);
    chk("alu_addr", bus.rf_addr, 5);
    chk("alu_data", bus.rf_data, 32'h1234);
    step();
    chk("alu_web_once", bus.rf_web, 0);
    chk("alu_addr_hold", bus.rf_addr, 5);
    chk("alu_wrcnt", bus.perf_wr_cnt, PERF ? 1 : 0);

    foreach (ld_vecs[i])
      do_load($sformatf("ld%0d", i), ld_vecs[i].f3, ld_vecs[i].lo, ld_vecs[i].exp);
    step();
    chk("ld_web_idle", bus.rf_web, 0);

    // ALU stream of 4 with two loads enqueued behind it
    for (int k = 0; k < 4; k++) begin
      bus.alu_valid = 1'b1;
      bus.alu_rd    = 5'(10 + k);
      bus.alu_data  = 32'hA000_0000 + 32'(k);
      if (k < 2) set_ld(5'(3 + k), 3'b010, 2'd0, 32'(16'h333 + 16'h111 * k));
      else bus.ld_valid = 1'b0;
      chk($sformatf("bp_ready%0d", k), bus.ld_ready, (k < 2) ? 1 : 0);
      step();
      chk($sformatf("bp_alu_addr%0d", k), bus.rf_addr, 10 + k);
      chk($sformatf("bp_alu_data%0d", k), bus.rf_data, 32'hA000_0000 + 32'(k));
    end
    idle_inputs();
    chk("bp_pend", bus.pend_mask, 32'h0000_0018);
    step();
    chk("bp_ld3_web", bus.rf_web, 1);
    chk("bp_ld3_addr", bus.rf_addr, 3);
    chk("bp_ld3_data", bus.rf_data, 32'h333);
    step();
    chk("bp_ld4_addr", bus.rf_addr, 4);
    chk("bp_ld4_data", bus.rf_data, 32'h444);
    step();
    chk("bp_web_idle", bus.rf_web, 0);
    chk("bp_ready_back", bus.ld_ready, 1);

    // kill: load x9, then ALU x9 next cycle
    set_ld(5'd9, 3'b010, 2'd0, 32'h0000_0999);
    step();
    bus.ld_valid = 1'b0;
    chk("kill_pend_set", bus.pend_mask[9], 1);
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd9;
    bus.alu_data  = 32'h0000_0ABC;
    step();
    bus.alu_valid = 1'b0;
    chk("kill_pend_clr", bus.pend_mask[9], 0);
    chk("kill_alu_web", bus.rf_web, 1);
    chk("kill_alu_data", bus.rf_data, 32'hABC);
    step();
    chk("kill_no_load", bus.rf_web, 0);
    step();
    chk("kill_idle", bus.rf_web, 0);
    chk("kill_cnt", bus.perf_kill_cnt, PERF ? 1 : 0);

    // x0 handling
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd0;
    bus.alu_data  = 32'hDEAD_BEEF;
    step();
    bus.alu_valid = 1'b0;
    chk("x0_alu_web", bus.rf_web, 0);
    set_ld(5'd0, 3'b010, 2'd0, 32'h1111_1111);
    chk("x0_ld_ready", bus.ld_ready, 1);
    step();
    bus.ld_valid = 1'b0;
    chk("x0_ld_pend", bus.pend_mask, 0);
    step();
    chk("x0_ld_web", bus.rf_web, 0);
    chk("x0_ld_addr_hold", bus.rf_addr, 9);
    chk("wr_cnt_total", bus.perf_wr_cnt, PERF ? 14 : 0);

    // reset with a queued load
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd13;
    bus.alu_data  = 32'h0000_000D;
    set_ld(5'd12, 3'b010, 2'd0, 32'h0000_000C);
    step();
    idle_inputs();
    chk("mr_pend", bus.pend_mask, 32'h0000_1000);
    rst = 1'b0;
    #1;
    chk("mr_ready_low", bus.ld_ready, 0);
    step();
    chk("mr_web", bus.rf_web, 0);
    chk("mr_pend_clr", bus.pend_mask, 0);
    chk("mr_wrcnt", bus.perf_wr_cnt, 0);
    rst = 1'b1;
    #1;
    chk("mr_ready_rel", bus.ld_ready, 1);
    step();
    chk("mr_no_write", bus.rf_web, 0);
    step();
    chk("mr_no_write2", bus.rf_web, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the core: merges single-cycle ALU results and multi-cycle load returns into the single register-file write port (rd port: web/addr/data). Loads are aligned and sign/zero-extended, then queued in a small FIFO. The ALU path has priority, and a younger ALU write kills any queued load to the same rd. A pending-write mask is exported for the decode-stage hazard check.

## Interface
- XLEN, 32, data width (from pkg_parameters)
- REG_ADDR_WIDTH, 5, register address width (from pkg_parameters)
- LQ_DEPTH, 2, load queue entries (≥1)
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset; synchronous, active-low (asserted when 0)
- alu_valid  in  1  ALU result valid this cycle; always accepted, no backpressure
- alu_rd  in  REG_ADDR_WIDTH  ALU destination register
- alu_data  in  XLEN  ALU result
- ld_valid  in  1  load return valid
- ld_ready  out  1  load queue can accept; transfer when ld_valid && ld_ready
- ld_rd  in  REG_ADDR_WIDTH  load destination register
- ld_funct3  in  3  load type (RV32I funct3)
- ld_addr_lo  in  2  byte offset of the load address
- ld_rdata  in  XLEN  raw aligned memory word
- rf_web  out  1  register-file write strobe, active-high
- rf_addr  out  REG_ADDR_WIDTH  write address
- rf_data  out  XLEN  write data
- pend_mask  out  2**REG_ADDR_WIDTH  bit r set while a live queued load targets xr
- perf_wr_cnt  out  32  count of register-file writes
- perf_kill_cnt  out  32  count of killed loads

## Operation
- Load alignment (combinational, applied at enqueue) uses `ld_funct3`:
  - 000 LB: byte ld_addr_lo, sign-extended
  - 100 LBU: byte ld_addr_lo, zero-extended
  - 001 LH: half ld_addr_lo[1], sign-extended
  - 101 LHU: half ld_addr_lo[1], zero-extended
  - 010 LW and all other codes: full word
  - ld_addr_lo[0] is ignored for halfwords; misalignment is trapped upstream.
- Load queue:
  - FIFO of {live, rd, data}, LQ_DEPTH entries, circular read/write pointers plus a count.
  - ld_ready = rst && (count < LQ_DEPTH). It depends on state only, so a dequeue in the same cycle does not free a slot for a full-queue enqueue.
- x0 handling:
  - A load with ld_rd==0 is handshaken and discarded; it is not enqueued.
  - An ALU write with alu_rd==0 produces no write.
- Select, each cycle, in priority order:
  - alu_valid && alu_rd≠0: the ALU result is registered to the output.
  - Otherwise, if the FIFO head is valid, it is dequeued. If live, it is registered to the output; a dead head is dropped silently.
  - Otherwise rf_web=0 next cycle.
- Kill:
  - When alu_valid && alu_rd≠0, every queued entry with rd==alu_rd is cleared to live=0.
  - This includes an entry being enqueued in the same cycle: its live bit is written as 0.
  - perf_kill_cnt increments by the number of live entries killed.
- pend_mask = OR of onehot(rd) over live entries. It is combinational from state.
- Simultaneous enqueue and dequeue are allowed when count < LQ_DEPTH. Pointers wrap modulo LQ_DEPTH.

## Timing
- ALU write: alu_valid at cycle N → rf_web=1 at N+1, for exactly one cycle per result.
- Load write: handshake at N → earliest rf_web at N+2 (enqueue at N, dequeue at N+1, output at N+2).
  - Each cycle with an ALU write delays the load by one cycle.
- Output registers rf_web/rf_addr/rf_data are updated every cycle. rf_addr/rf_data hold their previous value when rf_web=0.
- Reset values (while rst==0 at an edge):
  - rf_web=0, rf_addr=0, rf_data=0
  - pointers=0, count=0, all live bits=0, so pend_mask=0
  - both perf counters=0
  - ld_ready=0 while rst is low.
- Reset mid-operation: queued loads are discarded without writing. The first cycle after release has ld_ready=1.
- Perf counters wrap at 2^32.

## Configuration
- WB_PERF_CNT_EN defined:
  - perf_wr_cnt increments on every cycle rf_web=1.
  - perf_kill_cnt operates as described under Operation.
- WB_PERF_CNT_EN undefined: the ports remain, tied to 0, and no counter flops are built.

## Structure
- pkg_parameters gains:
  - ld_funct3_e enum (LB, LH, LW, LBU, LHU)
  - wb_entry_t packed struct {live, rd, data}
  - LQ_DEPTH default constant
- Sub-module load_align (combinational): inputs funct3, addr_lo, rdata; output aligned/extended XLEN data.
- wb_stage holds the FIFO, select/kill logic, output registers and counters.

## Test plan
- Reset:
  - Hold rst=0 for 3 cycles → rf_web=0, ld_ready=0, pend_mask=0, counters=0.
  - Release → ld_ready=1.
- ALU write: alu_valid, rd=5, data=0x0000_1234 at N → rf_web=1, rf_addr=5, rf_data=0x1234 at N+1 only.
- Load extension:
  - rdata=0x80FF_7F01, rd=7. LB, addr_lo=3 → rf_data=0xFFFF_FF80 at N+2.
  - LBU, addr_lo=3 → 0x0000_0080.
  - LH, addr_lo=2 → 0xFFFF_80FF.
  - LB, addr_lo=0 → 0x0000_0001.
- Priority and backpressure:
  - Enqueue two loads (rd=3, rd=4) while alu_valid is held for 4 cycles → ld_ready=0 after the second enqueue.
  - Load writes appear rd=3, then rd=4, in the two cycles after the ALU stream ends.
- Kill: load rd=9 enqueued at N, ALU rd=9 at N+1 → pend_mask[9] 1→0, a single write of ALU data to x9, perf_kill_cnt=1 (macro on).
- x0: ALU rd=0 → no write. Load rd=0 → handshaken, count stays 0, no write, pend_mask[0]=0.
